// File: rtl/rv32i_mc_sequencer.sv
// rv32i_mc_sequencer: multicycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer for the RV32I core
//
// Ports:
//   clk, reset_n (async, active-low)
//   run_en        : allow leaving FETCH (sampled only in FETCH)
//   opcode        : ir[6:0] from the decoder
//   branch_taken  : datapath compare result, used in EXECUTE
//   pc_write, ir_write, reg_write, dmem_wren : datapath strobes
//   alu_src_a, alu_src_b, writeback_src, pc_src : datapath mux selects
//   state         : FETCH=0 DECODE=1 EXECUTE=2 MEM_RD=3 MEM_WR=4 WB=5 HALT=6
//   instr_retired : equals pc_write
//   halted, illegal_instr : sticky status until reset
//   cycle_count, instret_count : present only when SEQ_PERF_CNT_EN is defined
module rv32i_mc_sequencer #(
    parameter int IMEM_LATENCY = 1,
    parameter int DMEM_LATENCY = 1,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_en,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       dmem_wren,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] writeback_src,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       instr_retired,
    output logic       halted,
    output logic       illegal_instr
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM_RD  = 3'd3,
        S_MEM_WR  = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] I_LAST = CNT_W'(IMEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DMEM_LATENCY - 1);

    state_t           st;
    logic [CNT_W-1:0] wait_cnt;
    logic             op_known;

    assign op_known = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                     OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign state = st;
    assign instr_retired = pc_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st            <= S_FETCH;
            wait_cnt      <= '0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (!run_en) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt == I_LAST) begin
                        wait_cnt <= '0;
                        st       <= S_DECODE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (opcode == OP_SYSTEM || !op_known) begin
                        st            <= S_HALT;
                        halted        <= 1'b1;
                        illegal_instr <= !op_known && opcode != OP_SYSTEM;
                    end else begin
                        st <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    st <= (opcode == OP_R || opcode == OP_I) ? S_WB :
                          (opcode == OP_LOAD)                ? S_MEM_RD :
                          (opcode == OP_STORE)               ? S_MEM_WR : S_FETCH;
                end
                S_MEM_RD, S_MEM_WR: begin
                    if (wait_cnt == D_LAST) begin
                        wait_cnt <= '0;
                        st       <= (st == S_MEM_RD) ? S_WB : S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB:    st <= S_FETCH;
                default: st <= S_HALT;
            endcase
        end
    end

    // While reset is asserted the decode is forced to the all-zero HALT row,
    // so no strobe can leak out before the state register is meaningful.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        dmem_wren     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        writeback_src = 2'b00;
        pc_src        = 2'b00;
        case (reset_n ? st : S_HALT)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = run_en && wait_cnt == I_LAST;
            end
            S_DECODE: alu_src_b = 2'b10;
            S_EXECUTE: begin
                case (opcode)
                    OP_R: alu_src_a = 2'b01;
                    OP_I, OP_LOAD, OP_STORE: begin
                        alu_src_a = 2'b01;
                        alu_src_b = 2'b10;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 2'b01;
                        pc_write  = 1'b1;
                        pc_src    = branch_taken ? 2'b01 : 2'b00;
                    end
                    OP_JAL: begin
                        reg_write     = 1'b1;
                        writeback_src = 2'b11;
                        pc_write      = 1'b1;
                        pc_src        = 2'b01;
                    end
                    OP_JALR: begin
                        alu_src_a     = 2'b01;
                        alu_src_b     = 2'b10;
                        reg_write     = 1'b1;
                        writeback_src = 2'b11;
                        pc_write      = 1'b1;
                        pc_src        = 2'b10;
                    end
                    OP_LUI: begin
                        reg_write     = 1'b1;
                        writeback_src = 2'b10;
                        pc_write      = 1'b1;
                    end
                    OP_AUIPC: begin
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM_WR: begin
                dmem_wren = wait_cnt == '0;
                pc_write  = wait_cnt == D_LAST;
            end
            S_WB: begin
                reg_write     = 1'b1;
                writeback_src = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                pc_write      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count   <= (st != S_HALT) ? cycle_count + 32'd1 : cycle_count;
            instret_count <= instr_retired ? instret_count + 32'd1 : instret_count;
        end
    end
`endif
endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// tb_rv32i_mc_sequencer: directed scoreboard bench for rv32i_mc_sequencer (IMEM=2, DMEM=3)
module tb_rv32i_mc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run_en = 1'b0;
    logic        branch_taken = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        pc_write, ir_write, reg_write, dmem_wren, instr_retired, halted, illegal_instr;
    logic [1:0]  alu_src_a, alu_src_b, writeback_src, pc_src;
    logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_count, instret_count;
`endif

    rv32i_mc_sequencer #(.IMEM_LATENCY(2), .DMEM_LATENCY(3), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .run_en(run_en), .opcode(opcode),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .dmem_wren(dmem_wren), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .writeback_src(writeback_src), .pc_src(pc_src),
        .state(state), .instr_retired(instr_retired), .halted(halted),
        .illegal_instr(illegal_instr)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       n;
        logic [17:0] v;
        logic [17:0] m;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    logic [17:0] obs;

    assign obs = {state, pc_write, ir_write, reg_write, dmem_wren, alu_src_a, alu_src_b,
                  writeback_src, pc_src, instr_retired, halted, illegal_instr};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (((obs ^ cur.v) & cur.m) != 18'd0) begin
                failures++;
                $display("FAIL %s got=%05h exp=%05h mask=%05h t=%0t", cur.n, obs, cur.v, cur.m, $time);
            end
        end
    end

    // One expected cycle: stb = {pc_write, ir_write, reg_write, dmem_wren}, hi = {halted, illegal}.
    // In reset cycles the mux selects are don't-care.
    task automatic cyc(input string n, input logic [2:0] s, input logic [3:0] stb,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] wb,
                       input logic [1:0] ps, input logic [1:0] hi, input bit rst_chk = 1'b0);
        exp_t e;
        e.n = n;
        e.v = {s, stb, a, b, wb, ps, stb[3], hi};
        e.m = rst_chk ? {7'h7f, 8'h00, 3'b111} : '1;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string n);
        cyc({n, "_f0"}, 3'd0, 4'b0000, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        cyc({n, "_f1"}, 3'd0, 4'b0100, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        cyc({n, "_dec"}, 3'd1, 4'b0000, 2'd0, 2'd2, 2'd0, 2'd0, 2'b00);
    endtask

    initial begin
        run_en = 1'b1;
        opcode = 7'b0110011;
        @(posedge clk);
        #1;
        cyc("rst0", 3'd0, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1);
        cyc("rst1", 3'd0, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1);
        reset_n = 1'b1;
        run_en = 1'b0;
        repeat (5) cyc("idle", 3'd0, 4'b0000, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        run_en = 1'b1;
        opcode = 7'b0110011;
        fetch("r");
        cyc("r_ex", 3'd2, 4'b0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'b00);
        cyc("r_wb", 3'd5, 4'b1010, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        opcode = 7'b0010011;
        fetch("i");
        cyc("i_ex", 3'd2, 4'b0000, 2'd1, 2'd2, 2'd0, 2'd0, 2'b00);
        cyc("i_wb", 3'd5, 4'b1010, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        opcode = 7'b0000011;
        fetch("ld");
        cyc("ld_ex", 3'd2, 4'b0000, 2'd1, 2'd2, 2'd0, 2'd0, 2'b00);
        repeat (3) cyc("ld_mem", 3'd3, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        cyc("ld_wb", 3'd5, 4'b1010, 2'd0, 2'd0, 2'd1, 2'd0, 2'b00);
        opcode = 7'b0100011;
        fetch("st");
        cyc("st_ex", 3'd2, 4'b0000, 2'd1, 2'd2, 2'd0, 2'd0, 2'b00);
        cyc("st_m0", 3'd4, 4'b0001, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        cyc("st_m1", 3'd4, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        cyc("st_m2", 3'd4, 4'b1000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        opcode = 7'b1100011;
        branch_taken = 1'b1;
        fetch("bt");
        cyc("bt_ex", 3'd2, 4'b1000, 2'd1, 2'd0, 2'd0, 2'd1, 2'b00);
        branch_taken = 1'b0;
        cyc("bn_f0", 3'd0, 4'b0000, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        cyc("bn_f1", 3'd0, 4'b0100, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        run_en = 1'b0;
        cyc("bn_dec", 3'd1, 4'b0000, 2'd0, 2'd2, 2'd0, 2'd0, 2'b00);
        cyc("bn_ex", 3'd2, 4'b1000, 2'd1, 2'd0, 2'd0, 2'd0, 2'b00);
        repeat (2) cyc("bn_hold", 3'd0, 4'b0000, 2'd0, 2'd1, 2'd0, 2'd0, 2'b00);
        run_en = 1'b1;
        opcode = 7'b1101111;
        fetch("jal");
        cyc("jal_ex", 3'd2, 4'b1010, 2'd0, 2'd0, 2'd3, 2'd1, 2'b00);
        opcode = 7'b1100111;
        fetch("jalr");
        cyc("jalr_ex", 3'd2, 4'b1010, 2'd1, 2'd2, 2'd3, 2'd2, 2'b00);
        opcode = 7'b0110111;
        fetch("lui");
        cyc("lui_ex", 3'd2, 4'b1010, 2'd0, 2'd0, 2'd2, 2'd0, 2'b00);
        opcode = 7'b0010111;
        fetch("auipc");
        cyc("auipc_ex", 3'd2, 4'b1010, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        opcode = 7'b1110011;
        fetch("sys");
        repeat (3) cyc("sys_halt", 3'd6, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b10);
        reset_n = 1'b0;
        cyc("rst2", 3'd0, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1);
        reset_n = 1'b1;
        opcode = 7'b1111111;
        fetch("ill");
        cyc("ill_h0", 3'd6, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b11);
        opcode = 7'b0110011;
        cyc("ill_h1", 3'd6, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b11);
        run_en = 1'b0;
        cyc("ill_h2", 3'd6, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b11);
        run_en = 1'b1;
        reset_n = 1'b0;
        cyc("rst3", 3'd0, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b1);
        reset_n = 1'b1;
        fetch("r2");
        cyc("r2_ex", 3'd2, 4'b0000, 2'd1, 2'd0, 2'd0, 2'd0, 2'b00);
        cyc("r2_wb", 3'd5, 4'b1010, 2'd0, 2'd0, 2'd0, 2'd0, 2'b00);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
